// File: rtl/gfx_pkg.sv
// Shared graphics constants and types: frame-buffer geometry, VGA 640x480@60
// timing, the RGB444 pixel layout and the sync/flag bundle used by scan-out.
package gfx_pkg;

  // Frame-buffer geometry (written by the rasterizer, read by scan-out)
  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_DEPTH  = FB_W * FB_H;
  localparam int PIX_W     = 12;
  localparam int FB_ADDR_W = 17;

  // System clocks per VGA pixel
  localparam int CLK_DIV = 4;

  // VGA 640x480@60 horizontal timing, in pixels
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  // VGA 640x480@60 vertical timing, in lines
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // One RGB444 pixel as stored in the frame buffer
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Per-pixel flags that travel down the scan-out pipeline beside the colour
  typedef struct packed {
    logic active;
    logic hsync_n;
    logic vsync_n;
    logic vblank;
    logic frame_start;
  } scan_flags_t;

  // Idle flag value: blanked, syncs deasserted, no strobes
  localparam scan_flags_t FLAGS_IDLE = '{
    active:      1'b0,
    hsync_n:     1'b1,
    vsync_n:     1'b1,
    vblank:      1'b0,
    frame_start: 1'b0
  };

  // Address of the first pixel of the bottom frame-buffer row (shown on line 0)
  function automatic int unsigned fb_top_base(input int unsigned w, input int unsigned h);
    return (h - 1) * w;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider, horizontal/vertical counters and
// the combinational active/sync/vblank/frame-start flags for the current pixel.
// The first divider tick after reset or enable lands on pixel (0,0) rather than
// stepping past it, so every frame starts with its top-left pixel.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_enable,
  output logic          o_pix_start,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_active,
  output logic          o_hsync_n,
  output logic          o_vsync_n,
  output logic          o_vblank,
  output logic          o_frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DW       = $clog2(CLK_DIV);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          run_q, run_d;
  logic          pix_q, pix_d;
  logic          tick;

  assign tick = (div_q == DW'(CLK_DIV - 1));

  // Next state: divider every clk, raster position on each pixel tick
  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    run_d = run_q;
    pix_d = 1'b0;
    if (!i_enable) begin
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
      run_d = 1'b0;
    end else begin
      div_d = tick ? '0 : div_q + DW'(1);
      if (tick) begin
        pix_d = 1'b1;
        if (!run_q) begin
          run_d = 1'b1;
        end else if (h_q == HW'(H_TOTAL - 1)) begin
          h_d = '0;
          v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
        end else begin
          h_d = h_q + HW'(1);
        end
      end
    end
  end

  // Counter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      run_q <= 1'b0;
      pix_q <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      run_q <= run_d;
      pix_q <= pix_d;
    end
  end

  assign o_pix_start   = pix_q;
  assign o_h_cnt       = h_q;
  assign o_v_cnt       = v_q;
  assign o_active      = run_q && (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
  assign o_hsync_n     = !(run_q && (h_q >= HW'(HS_START)) && (h_q < HW'(HS_END)));
  assign o_vsync_n     = !(run_q && (v_q >= VW'(VS_START)) && (v_q < VW'(VS_END)));
  assign o_vblank      = run_q && (v_q >= VW'(V_ACTIVE));
  assign o_frame_start = pix_q && run_q && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_scanout.sv
// Frame-buffer scan-out to VGA. Each frame-buffer pixel covers 2x2 screen
// pixels and the image is flipped vertically: the bottom frame-buffer row is
// shown first. Row bases are stepped incrementally, and the colour plus flags
// leave through a 3-stage pipeline (address, memory read, output register).
module vga_scanout #(
  parameter int FB_W     = gfx_pkg::FB_W,
  parameter int FB_H     = gfx_pkg::FB_H,
  parameter int ADDR_W   = gfx_pkg::FB_ADDR_W,
  parameter int PIX_W    = gfx_pkg::PIX_W,
  parameter int CLK_DIV  = gfx_pkg::CLK_DIV,
  parameter int H_ACTIVE = gfx_pkg::H_ACTIVE,
  parameter int H_FP     = gfx_pkg::H_FP,
  parameter int H_SYNC   = gfx_pkg::H_SYNC,
  parameter int H_BP     = gfx_pkg::H_BP,
  parameter int V_ACTIVE = gfx_pkg::V_ACTIVE,
  parameter int V_FP     = gfx_pkg::V_FP,
  parameter int V_SYNC   = gfx_pkg::V_SYNC,
  parameter int V_BP     = gfx_pkg::V_BP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  output logic [ADDR_W-1:0] o_fb_addr,
  output logic              o_fb_re,
  input  logic [PIX_W-1:0]  i_fb_data,
  output logic [3:0]        o_vga_r,
  output logic [3:0]        o_vga_g,
  output logic [3:0]        o_vga_b,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_vblank,
  output logic              o_frame_start
);

  import gfx_pkg::*;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam logic [ADDR_W-1:0] TOP_BASE = ADDR_W'(fb_top_base(FB_W, FB_H));
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

  logic          pix_start;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  scan_flags_t   cur_flags;

  vga_timing_gen #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_enable      (i_enable),
    .o_pix_start   (pix_start),
    .o_h_cnt       (h_cnt),
    .o_v_cnt       (v_cnt),
    .o_active      (cur_flags.active),
    .o_hsync_n     (cur_flags.hsync_n),
    .o_vsync_n     (cur_flags.vsync_n),
    .o_vblank      (cur_flags.vblank),
    .o_frame_start (cur_flags.frame_start)
  );

  // Stage 1: address/strobe and the flags of the pixel being fetched
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic              fb_re_q, fb_re_d;
  scan_flags_t       s1_q, s1_d;
  // Stage 2: memory read in flight
  scan_flags_t       s2_q, s2_d;
  logic              s2_re_q, s2_re_d;
  // Stage 3: registered pins
  scan_flags_t       out_q, out_d;
  rgb444_t           rgb_q, rgb_d;

  logic [ADDR_W-1:0] col;
  logic              line_end;

  assign col      = ADDR_W'(h_cnt >> 1);
  assign line_end = pix_start && (h_cnt == HW'(H_TOTAL - 1));

  // Pipeline next state; a low enable clears every stage to its idle value
  always_comb begin
    row_base_d = row_base_q;
    fb_addr_d  = fb_addr_q;
    fb_re_d    = 1'b0;
    s1_d       = s1_q;
    s2_d       = s2_q;
    s2_re_d    = 1'b0;
    out_d      = out_q;
    rgb_d      = rgb_q;
    if (!i_enable) begin
      row_base_d = TOP_BASE;
      fb_addr_d  = '0;
      s1_d       = FLAGS_IDLE;
      s2_d       = FLAGS_IDLE;
      out_d      = FLAGS_IDLE;
      rgb_d      = '0;
    end else begin
      // One read per screen pixel; each source pixel is fetched twice per line
      if (pix_start && cur_flags.active) begin
        fb_re_d   = 1'b1;
        fb_addr_d = row_base_q + col;
      end
      // Step up one source row after every second active line; the last
      // active line keeps base 0 so the register never wraps, and the final
      // pixel of the frame reloads the bottom row for the next frame.
      if (line_end) begin
        if (v_cnt == VW'(V_TOTAL - 1)) begin
          row_base_d = TOP_BASE;
        end else if (v_cnt[0] && (v_cnt < VW'(V_ACTIVE - 1))) begin
          row_base_d = row_base_q - ROW_STEP;
        end
      end
      s1_d    = cur_flags;
      s2_d    = s1_q;
      s2_re_d = fb_re_q;
      out_d   = s2_q;
      // Capture read data on the clk it arrives; hold it for the rest of the
      // pixel period and force black outside the active region.
      if (s2_re_q) begin
        rgb_d = rgb444_t'(i_fb_data[11:0]);
      end else if (!s2_q.active) begin
        rgb_d = '0;
      end
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base_q <= TOP_BASE;
      fb_addr_q  <= '0;
      fb_re_q    <= 1'b0;
      s1_q       <= FLAGS_IDLE;
      s2_q       <= FLAGS_IDLE;
      s2_re_q    <= 1'b0;
      out_q      <= FLAGS_IDLE;
      rgb_q      <= '0;
    end else begin
      row_base_q <= row_base_d;
      fb_addr_q  <= fb_addr_d;
      fb_re_q    <= fb_re_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s2_re_q    <= s2_re_d;
      out_q      <= out_d;
      rgb_q      <= rgb_d;
    end
  end

  assign o_fb_addr     = fb_addr_q;
  assign o_fb_re       = fb_re_q;
  assign o_vga_r       = rgb_q.r;
  assign o_vga_g       = rgb_q.g;
  assign o_vga_b       = rgb_q.b;
  assign o_hsync       = out_q.hsync_n;
  assign o_vsync       = out_q.vsync_n;
  assign o_vblank      = out_q.vblank;
  assign o_frame_start = out_q.frame_start;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout. A full-size instance covers reset, the first
// pixels, doubling, the row step and hsync; a shrunken-timing instance covers
// frame-level behaviour (vsync, vblank, frame spacing, enable drop, async reset).
// Cycle k means the k-th rising edge after reset release / enable; outputs are
// sampled on the falling edge that follows.
module tb_vga_scanout;
  import gfx_pkg::*;

  localparam int S_FB_W = 8;
  localparam int S_FB_H = 6;
  localparam int S_DEPTH = S_FB_W * S_FB_H;

  logic clk, rst_n, en_full, en_small;

  logic [16:0] addr_f, addr_s;
  logic        re_f, re_s;
  logic [11:0] rd_f, rd_s;
  logic [3:0]  r_f, g_f, b_f, r_s, g_s, b_s;
  logic        hs_f, vs_f, vb_f, fs_f, hs_s, vs_s, vb_s, fs_s;

  logic [11:0] fb_f [0:FB_DEPTH-1];
  logic [11:0] fb_s [0:S_DEPTH-1];

  int cyc_full, cyc_small;
  int n_checks, n_errors;

  vga_scanout u_full (
    .clk(clk), .rst_n(rst_n), .i_enable(en_full),
    .o_fb_addr(addr_f), .o_fb_re(re_f), .i_fb_data(rd_f),
    .o_vga_r(r_f), .o_vga_g(g_f), .o_vga_b(b_f),
    .o_hsync(hs_f), .o_vsync(vs_f), .o_vblank(vb_f), .o_frame_start(fs_f)
  );

  vga_scanout #(
    .FB_W(S_FB_W), .FB_H(S_FB_H), .ADDR_W(17), .PIX_W(12), .CLK_DIV(4),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .i_enable(en_small),
    .o_fb_addr(addr_s), .o_fb_re(re_s), .i_fb_data(rd_s),
    .o_vga_r(r_s), .o_vga_g(g_s), .o_vga_b(b_s),
    .o_hsync(hs_s), .o_vsync(vs_s), .o_vblank(vb_s), .o_frame_start(fs_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read frame-buffer models (1-clk latency)
  always @(posedge clk) begin
    if (re_f && addr_f < FB_DEPTH) rd_f <= fb_f[addr_f];
    if (re_s && addr_s < S_DEPTH)  rd_s <= fb_s[addr_s];
  end

  // Edge counters since reset release / enable
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_full  <= 0;
      cyc_small <= 0;
    end else begin
      cyc_full  <= en_full  ? cyc_full + 1  : 0;
      cyc_small <= en_small ? cyc_small + 1 : 0;
    end
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end else begin
      $display("ok   %s: got %0d", tag, got);
    end
  endtask

  task automatic wait_full(input int k);
    while (cyc_full < k) @(negedge clk);
  endtask

  task automatic wait_small(input int k);
    while (cyc_small < k) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    en_full  = 1'b1;
    en_small = 1'b0;
    for (int i = 0; i < FB_DEPTH; i++) fb_f[i] = 12'h000;
    fb_f[76480] = 12'hABC;
    fb_f[76481] = 12'h123;
    for (int i = 0; i < S_DEPTH; i++) fb_s[i] = 12'(i);

    // Reset values while held in reset with enable high
    #23;
    check_eq("rst_addr",   addr_f, 0);
    check_eq("rst_re",     re_f, 0);
    check_eq("rst_rgb",    {r_f, g_f, b_f}, 0);
    check_eq("rst_hsync",  hs_f, 1);
    check_eq("rst_vsync",  vs_f, 1);
    check_eq("rst_vblank", vb_f, 0);
    check_eq("rst_fs",     fs_f, 0);

    @(negedge clk);
    rst_n = 1'b1;

    // First pixels, flip and doubling on the full-size instance
    wait_full(4);    check_eq("re_before_tick", re_f, 0);
    wait_full(5);    check_eq("first_re", re_f, 1);
                     check_eq("first_addr", addr_f, 76480);
    wait_full(6);    check_eq("re_one_clk", re_f, 0);
    wait_full(7);    check_eq("px0_rgb", {r_f, g_f, b_f}, 12'hABC);
                     check_eq("px0_fs", fs_f, 1);
                     check_eq("px0_hsync", hs_f, 1);
                     check_eq("px0_vblank", vb_f, 0);
    wait_full(8);    check_eq("fs_one_clk", fs_f, 0);
    wait_full(10);   check_eq("px0_hold", {r_f, g_f, b_f}, 12'hABC);
    wait_full(11);   check_eq("px1_rgb", {r_f, g_f, b_f}, 12'hABC);
    wait_full(15);   check_eq("px2_rgb", {r_f, g_f, b_f}, 12'h123);
    wait_full(19);   check_eq("px3_rgb", {r_f, g_f, b_f}, 12'h123);
    wait_full(2561); check_eq("l0_last_re", re_f, 1);
                     check_eq("l0_last_addr", addr_f, 76799);
    wait_full(2565); check_eq("hblank_no_re", re_f, 0);
    wait_full(2630); check_eq("hs_pre", hs_f, 1);
    wait_full(2631); check_eq("hs_fall", hs_f, 0);
    wait_full(3014); check_eq("hs_last_low", hs_f, 0);
    wait_full(3015); check_eq("hs_rise", hs_f, 1);
    wait_full(3205); check_eq("l1_addr", addr_f, 76480);
    wait_full(5830); check_eq("hs2_pre", hs_f, 1);
    wait_full(5831); check_eq("hs2_fall", hs_f, 0);
    for (int i = 0; i < 6; i++) begin
      wait_full(6405 + 4 * i);
      check_eq($sformatf("l2_addr%0d", i), addr_f, 76160 + i / 2);
    end

    // Frame-level behaviour on the shrunken instance (24x16 pixels, 8x6 fb)
    @(negedge clk);
    en_small = 1'b1;
    wait_small(5);    check_eq("s_first_addr", addr_s, 40);
                      check_eq("s_first_re", re_s, 1);
    wait_small(7);    check_eq("s_fs", fs_s, 1);
                      check_eq("s_px0_rgb", {r_s, g_s, b_s}, 40);
    wait_small(8);    check_eq("s_fs_end", fs_s, 0);
    wait_small(69);   check_eq("s_hblank_re", re_s, 0);
    wait_small(78);   check_eq("s_hs_pre", hs_s, 1);
    wait_small(79);   check_eq("s_hs_fall", hs_s, 0);
    wait_small(94);   check_eq("s_hs_low", hs_s, 0);
    wait_small(95);   check_eq("s_hs_rise", hs_s, 1);
    wait_small(1121); check_eq("s_last_re", re_s, 1);
                      check_eq("s_last_addr", addr_s, 7);
    wait_small(1123); check_eq("s_last_rgb", {r_s, g_s, b_s}, 7);
    wait_small(1157); check_eq("s_vblank_re", re_s, 0);
    wait_small(1158); check_eq("s_vb_pre", vb_s, 0);
    wait_small(1159); check_eq("s_vb_rise", vb_s, 1);
                      check_eq("s_vb_rgb", {r_s, g_s, b_s}, 0);
    wait_small(1254); check_eq("s_vs_pre", vs_s, 1);
    wait_small(1255); check_eq("s_vs_fall", vs_s, 0);
    wait_small(1446); check_eq("s_vs_low", vs_s, 0);
    wait_small(1447); check_eq("s_vs_rise", vs_s, 1);
    wait_small(1541); check_eq("s_f2_addr", addr_s, 40);
    wait_small(1542); check_eq("s_f2_fs_pre", fs_s, 0);
                      check_eq("s_vb_last", vb_s, 1);
    wait_small(1543); check_eq("s_f2_fs", fs_s, 1);
                      check_eq("s_vb_fall", vb_s, 0);

    // Enable drop mid-line (pixel (7,3) on screen)
    wait_small(1860); check_eq("s_pre_drop_rgb", {r_s, g_s, b_s}, 35);
    en_small = 1'b0;
    @(negedge clk);
    check_eq("drop_rgb", {r_s, g_s, b_s}, 0);
    check_eq("drop_re", re_s, 0);
    check_eq("drop_addr", addr_s, 0);
    check_eq("drop_hsync", hs_s, 1);
    check_eq("drop_vsync", vs_s, 1);
    check_eq("drop_vblank", vb_s, 0);
    repeat (9) @(negedge clk);
    en_small = 1'b1;
    wait_small(5);  check_eq("reen_addr", addr_s, 40);
                    check_eq("reen_re", re_s, 1);
    wait_small(7);  check_eq("reen_fs", fs_s, 1);
                    check_eq("reen_rgb", {r_s, g_s, b_s}, 40);
    wait_small(20); check_eq("pre_rst_rgb", {r_s, g_s, b_s}, 41);

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_rgb", {r_s, g_s, b_s}, 0);
    check_eq("arst_addr", addr_s, 0);
    check_eq("arst_hsync", hs_s, 1);
    check_eq("arst_fs", fs_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_small(5); check_eq("post_rst_addr", addr_s, 40);
                   check_eq("post_rst_re", re_s, 1);
    wait_small(7); check_eq("post_rst_fs", fs_s, 1);
                   check_eq("post_rst_rgb", {r_s, g_s, b_s}, 40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
